// File: rtl/updown_count_arbiter.sv
// rtl/updown_count_arbiter.sv - shared 3-bit up/down burst counter with two-client arbiter (option: ARB_FIXED_PRIO_EN)
module updown_count_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       dir0,
    input  logic [2:0] steps0,
    input  logic       req1,
    input  logic       dir1,
    input  logic [2:0] steps1,
    input  logic       hold,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [2:0] count,
    output logic       busy,
    output logic       owner
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_rr_last;
    logic       r_owner;
    logic       r_dir;
    logic [2:0] r_rem;
    logic [2:0] r_count;
    logic       r_done0;
    logic       r_done1;

    logic       w_any;
    logic       w_pick;
    logic       w_pick_dir;
    logic [2:0] w_pick_steps;
    logic       w_burst_owner;

    assign w_any = req0 | req1;

`ifdef ARB_FIXED_PRIO_EN
    // Client 0 wins every tie; rr_last is still tracked but not consulted.
    assign w_pick = req1 & ~req0;
`else
    // On a tie, serve the client that did not finish the previous burst.
    assign w_pick = (req0 & req1) ? ~r_rr_last : req1;
`endif

    assign w_pick_dir   = w_pick ? dir1   : dir0;
    assign w_pick_steps = w_pick ? steps1 : steps0;

    // Owner of the burst heading into DONE: the new winner when leaving IDLE.
    assign w_burst_owner = (r_state == S_IDLE) ? w_pick : r_owner;

    // Next-state and grant decode; grants only exist in IDLE outside reset.
    always_comb begin
        w_next = r_state;
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rst && w_any) begin
                    gnt0   = ~w_pick;
                    gnt1   = w_pick;
                    w_next = (w_pick_steps != 3'd0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (!hold && r_rem == 3'd1) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register; reset abandons any burst in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Burst datapath: latch fields on grant, step the counter while not held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count   <= 3'd0;
            r_owner   <= 1'b0;
            r_rr_last <= 1'b1;
            r_dir     <= 1'b0;
            r_rem     <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner <= w_pick;
                        r_dir   <= w_pick_dir;
                        r_rem   <= w_pick_steps;
                    end
                end
                S_RUN: begin
                    if (!hold) begin
                        r_count <= r_dir ? (r_count + 3'd1) : (r_count - 3'd1);
                        r_rem   <= r_rem - 3'd1;
                    end
                end
                S_DONE: begin
                    r_rr_last <= r_owner;
                end
                default: begin
                    r_rem <= 3'd0;
                end
            endcase
        end
    end

    // Completion pulses are registered so they coincide with the DONE cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
        end else begin
            r_done0 <= (w_next == S_DONE) && (r_state != S_DONE) && !w_burst_owner;
            r_done1 <= (w_next == S_DONE) && (r_state != S_DONE) &&  w_burst_owner;
        end
    end

    assign done0 = r_done0;
    assign done1 = r_done1;
    assign count = r_count;
    assign owner = r_owner;
    assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_updown_count_arbiter.sv
// tb/tb_updown_count_arbiter.sv - randomized bench for updown_count_arbiter against a queue-based burst model
module tb_updown_count_arbiter;

    logic       clk;
    logic       rst;
    logic       req0;
    logic       dir0;
    logic [2:0] steps0;
    logic       req1;
    logic       dir1;
    logic [2:0] steps1;
    logic       hold;
    logic       gnt0;
    logic       gnt1;
    logic       done0;
    logic       done1;
    logic [2:0] count;
    logic       busy;
    logic       owner;

    int n_checks;
    int n_pass;

    // Reference model: a burst is a queue of pending count deltas (+1/-1)
    // followed by a 0 marking the completion cycle.
    int m_q[$];
    int m_count;
    int m_owner;
    int m_last;
    int e_gnt0;
    int e_gnt1;
    int e_done0;
    int e_done1;
    int e_busy;
    int drop0;
    int drop1;

    updown_count_arbiter dut (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .dir0   (dir0),
        .steps0 (steps0),
        .req1   (req1),
        .dir1   (dir1),
        .steps1 (steps1),
        .hold   (hold),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .done0  (done0),
        .done1  (done1),
        .count  (count),
        .busy   (busy),
        .owner  (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_count = 0;
        m_owner = 0;
        m_last  = 1;
    endtask

    task automatic model_expect();
        int winner;
        e_gnt0 = 0;
        e_gnt1 = 0;
        if (rst && m_q.size() == 0 && (req0 || req1)) begin
            if (req0 && req1) begin
`ifdef ARB_FIXED_PRIO_EN
                winner = 0;
`else
                winner = (m_last == 1) ? 0 : 1;
`endif
            end else begin
                winner = req1 ? 1 : 0;
            end
            if (winner == 0) e_gnt0 = 1;
            else             e_gnt1 = 1;
        end
        e_busy  = (m_q.size() != 0) ? 1 : 0;
        e_done0 = (m_q.size() != 0 && m_q[0] == 0 && m_owner == 0) ? 1 : 0;
        e_done1 = (m_q.size() != 0 && m_q[0] == 0 && m_owner == 1) ? 1 : 0;
    endtask

    task automatic model_step();
        int n;
        int d;
        if (!rst) begin
            model_reset();
        end else if (m_q.size() == 0) begin
            if (e_gnt0 || e_gnt1) begin
                m_owner = e_gnt1;
                n = e_gnt1 ? int'(steps1) : int'(steps0);
                d = (e_gnt1 ? dir1 : dir0) ? 1 : -1;
                for (int k = 0; k < n; k++) m_q.push_back(d);
                m_q.push_back(0);
            end
        end else if (m_q[0] == 0) begin
            m_last = m_owner;
            void'(m_q.pop_front());
        end else if (!hold) begin
            m_count = (m_count + m_q[0] + 8) % 8;
            void'(m_q.pop_front());
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        drop0    = 0;
        drop1    = 0;
        rst      = 1'b0;
        req0     = 1'b0;
        dir0     = 1'b0;
        steps0   = 3'd0;
        req1     = 1'b0;
        dir1     = 1'b0;
        steps1   = 3'd0;
        hold     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            #1;
            // Clients: drop a request after its grant, otherwise raise new
            // commands at random and hold the fields while waiting.
            if (drop0) begin
                req0 = 1'b0;
            end else if (!req0 && ($urandom % 3) == 0) begin
                req0   = 1'b1;
                dir0   = 1'($urandom);
                steps0 = 3'($urandom);
            end
            if (drop1) begin
                req1 = 1'b0;
            end else if (!req1 && ($urandom % 3) == 0) begin
                req1   = 1'b1;
                dir1   = 1'($urandom);
                steps1 = 3'($urandom);
            end
            hold = (($urandom % 4) == 0);
            rst  = (cyc < 5) ? 1'b1 : ((($urandom % 80) == 0) ? 1'b0 : 1'b1);
            #3;
            model_expect();
            chk("gnt0",  int'(gnt0),  e_gnt0);
            chk("gnt1",  int'(gnt1),  e_gnt1);
            chk("done0", int'(done0), e_done0);
            chk("done1", int'(done1), e_done1);
            chk("busy",  int'(busy),  e_busy);
            chk("count", int'(count), m_count);
            chk("owner", int'(owner), m_owner);
            drop0 = e_gnt0;
            drop1 = e_gnt1;
            model_step();
            @(posedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/updown_count_arbiter.md
# updown_count_arbiter

Shared 3-bit up/down counter with a two-client command arbiter. Each client requests a burst of N single steps (up or down, modulo 8). The block grants one client at a time, round-robin by default, and executes the burst on the shared count register. It signals completion to the owning client. It sits between two control agents and the 3-bit count value they both consume.

## Interface
Parameters:
- none; count width fixed at 3, step field fixed at 3.

Ports:
- clk  input  1  rising-edge clock; sole clock.
- rst  input  1  synchronous, active-low reset, sampled on rising clk.
- req0  input  1  client 0 command request; held high until gnt0 seen.
- dir0  input  1  client 0 direction: 1 = up, 0 = down.
- steps0  input  3  client 0 step count, 0..7.
- req1  input  1  client 1 command request.
- dir1  input  1  client 1 direction.
- steps1  input  3  client 1 step count.
- hold  input  1  stall; while high in RUN, no step is taken.
- gnt0  output  1  combinational accept pulse for client 0.
- gnt1  output  1  combinational accept pulse for client 1.
- done0  output  1  registered one-cycle completion pulse, client 0.
- done1  output  1  registered one-cycle completion pulse, client 1.
- count  output  3  shared counter value.
- busy  output  1  high in RUN and DONE.
- owner  output  1  client index of the current or last burst.

## Operation
- Reset (rst=0 at an edge): count=0, busy=0, owner=0, done0/1=0, state=IDLE, rr_last=1. gnt0/1 are forced 0 while rst=0. Reset overrides all other inputs. A reset during RUN aborts the burst: no done pulse, no partial completion.
- States: IDLE, RUN, DONE.
- IDLE:
  - No req: stay.
  - One req: grant that client.
  - Both req: grant the client that is not rr_last.
  - The grant cycle asserts gnt_i combinationally. The next edge latches dir_i, steps_i into dir_q, rem, and sets owner=i.
  - Next state is RUN if steps_i≠0, else DONE.
- RUN, each edge with hold=0:
  - Up: count=count+1, wrapping 7→0.
  - Down: count=count−1, wrapping 0→7.
  - rem=rem−1. When rem was 1, next state is DONE.
- RUN with hold=1: count and rem unchanged; state unchanged.
- DONE: done_owner=1 for exactly this cycle; rr_last=owner. Next state is IDLE.
- gnt is 0 in RUN and DONE. A client with req high waits, fields held stable.
- Fields are sampled only on the grant edge; later changes have no effect.
- Arithmetic: 3-bit modulo 8; rem is 3 bits and never underflows.

## Timing
- Grant cycle G (gnt_i=1). First count change at edge G+1. Step k lands at edge G+k.
- DONE occupies cycle G+N+1, where done_i=1. IDLE at G+N+2, which is the earliest next grant.
- Burst of N≥1 steps with hold=0 occupies N+2 cycles, grant to next grant. N=0 occupies 2 cycles with count untouched.
- Each hold cycle in RUN extends the burst by one cycle.
- busy rises at edge G and falls at edge G+N+1.
- Back-to-back bursts: minimum one IDLE cycle (the next grant cycle) between done and the next count change.

## Configuration
- ARB_FIXED_PRIO_EN defined: client 0 always wins when both request. rr_last is still updated but ignored; client 1 can starve.
- ARB_FIXED_PRIO_EN undefined (default): round-robin as described. Ties alternate and the first tie after reset goes to client 0.

## Test plan
- Reset then a single burst:
  - Stimulus: rst low 2 cycles; req0=1, dir0=1, steps0=3.
  - Response: gnt0 one cycle. count 1, 2, 3 on the next 3 edges. done0 one cycle later. busy high 4 cycles. owner=0.
- Down-wrap:
  - Stimulus: count=1; client 1 dir1=0, steps1=4.
  - Response: count 0, 7, 6, 5. done1 pulse, done0 stays 0.
- Simultaneous requests:
  - Stimulus: req0 and req1 high from reset, both steps=1.
  - Response (round-robin): grant order 0, 1, 0.
  - Response (ARB_FIXED_PRIO_EN): grant order 0, 0, 0 while req0 stays high.
- Zero steps and hold:
  - Stimulus: steps0=0.
  - Response: done0 in the cycle after gnt0, count unchanged.
  - Stimulus: steps0=2 with hold=1 for 3 RUN cycles.
  - Response: burst takes 7 cycles grant-to-grant, count +2.
- Reset mid-burst:
  - Stimulus: steps0=7, rst=0 after 3 steps.
  - Response: next edge count=0, busy=0, no done0. A pending req1 is granted after rst=1 (rr_last=1 → tie favors 0).
- Request during busy:
  - Stimulus: req1 rises mid-burst of client 0.
  - Response: gnt1 stays 0 until IDLE, then gnt1 on the first IDLE cycle.
